// File: rtl/led_activity_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : led_activity_stretcher
// Purpose  : Stretches per-channel activity strobes into visible LED blinks
//            with a guaranteed off-gap, plus a lock-dependent heartbeat LED.
// Revision : 1.0 - initial release
// ============================================================================
module led_activity_stretcher #(
  parameter int N_CH      = 2,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            d25,
  input  logic            d28,
  input  logic [N_CH-1:0] act,
  input  logic            locked,
  output logic [N_CH-1:0] led,
  output logic            hb,
  output logic            tick
);

  localparam logic [3:0] c_ON_CNT  = 4'(ON_TICKS);
  localparam logic [3:0] c_OFF_CNT = 4'(OFF_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  logic d25_q;
  logic hb_q;

  // d25_q resets high so a divider output already high at release is not a tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d25_q <= 1'b1;
      hb_q  <= 1'b0;
    end else begin
      d25_q <= d25;
      hb_q  <= locked ? d28 : d25;
    end
  end

  assign tick = d25 & ~d25_q;
  assign hb   = hb_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       want_on;

    assign want_on = act[gi] | pend_q;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      case (state_q)
        ST_IDLE: begin
          if (want_on) begin
            state_d = ST_ON;
            cnt_d   = c_ON_CNT;
            pend_d  = 1'b0;
          end
        end
        ST_ON: begin
          if (act[gi]) pend_d = 1'b1;
          if (tick) begin
            if (cnt_q == 4'd1) begin
              state_d = ST_OFF;
              cnt_d   = c_OFF_CNT;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        ST_OFF: begin
          if (act[gi]) pend_d = 1'b1;
          if (tick) begin
            if (cnt_q == 4'd1) begin
              // Pending activity restarts the blink directly, skipping IDLE.
              if (want_on) begin
                state_d = ST_ON;
                cnt_d   = c_ON_CNT;
                pend_d  = 1'b0;
              end else begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
              end
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          pend_d  = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= 4'd0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
      end
    end

    assign led[gi] = (state_q == ST_ON);
  end

endmodule
`default_nettype wire

// File: doc/led_activity_stretcher.md
LED_ACTIVITY_STRETCHER -- requirements
Module: led_activity_stretcher

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of activity channels (1..8).
REQ-002 SHALL have parameter ON_TICKS, default 4, LED on-time in ticks (1..15).
REQ-003 SHALL have parameter OFF_TICKS, default 2, guaranteed LED off-gap in ticks (1..15).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port d25  input  1  slow divided square wave from the clock divider, synchronous to clk.
REQ-007 SHALL have port d28  input  1  slower divided square wave from the clock divider, synchronous to clk.
REQ-008 SHALL have port act  input  N_CH  per-channel activity strobes, any width, level or pulse.
REQ-009 SHALL have port locked  input  1  clock-lock status; selects heartbeat rate.
REQ-010 SHALL have port led  output  N_CH  stretched per-channel LED drive, active-high.
REQ-011 SHALL have port hb  output  1  heartbeat LED drive.
REQ-012 SHALL have port tick  output  1  one-clk pulse on each d25 rising edge, for debug.

Function
REQ-013 SHALL register d25 into d25_r; tick = d25 & ~d25_r, high for exactly one clk per d25 rising edge.
REQ-014 SHALL keep per-channel state machine with states IDLE, ON, OFF and a 4-bit tick counter cnt.
REQ-015 SHALL drive led[i] = 1 only when channel i state is ON (Moore, decoded from state register).
REQ-016 IDLE: if act[i]=1 or pend[i]=1 -> ON, cnt <= ON_TICKS, pend[i] <= 0.
REQ-017 ON: on tick, cnt decrements; on tick with cnt=1 -> OFF, cnt <= OFF_TICKS.
REQ-018 OFF: on tick, cnt decrements; on tick with cnt=1 -> ON (cnt <= ON_TICKS, pend[i] <= 0) if pend[i]=1 or act[i]=1, else IDLE.
REQ-019 SHALL set pend[i] on any cycle act[i]=1 in which the channel does not enter ON; pend is 1 bit (multiple strobes collapse to one).
REQ-020 Latency act[i] -> led[i] high from IDLE SHALL be exactly 1 clk.
REQ-021 On-time SHALL lie between ON_TICKS-1 and ON_TICKS tick periods plus at most 1 clk (first tick asynchronous to entry); off-gap likewise with OFF_TICKS.
REQ-022 Continuous act[i]=1 SHALL produce a repeating ON/OFF pattern; led[i] SHALL never remain high through an OFF period.
REQ-023 Channels SHALL be fully independent; tick and d25_r shared.
REQ-024 SHALL register hb <= d28 when locked=1, hb <= d25 when locked=0 (fast blink signals loss of lock); locked change takes effect next clk.
REQ-025 tick and state update in the same cycle SHALL use the pre-update cnt value; no counter underflow below 1 is permitted.

Reset
REQ-026 On clk edge with rst_n=0: all channel states IDLE, cnt=0, pend=0, led=0, hb=0, tick=0.
REQ-027 d25_r SHALL reset to 1 so d25 already high at reset release produces no tick.
REQ-028 rst_n=0 for a single cycle mid-operation SHALL abort any ON/OFF period; led=0 on the cycle after reset is sampled; no act before reset is remembered.

Verification
REQ-029 Defaults, d25 toggling every 8 clk (tick every 16 clk): single 1-clk act[0] pulse -> led[0]=1 next clk, stays high until the 4th tick after entry, then 0 for 2 ticks, then IDLE with no retrigger; led[1]=0 throughout.
REQ-030 act[0] held high 200 clk -> led[0] pattern high 3-4 tick periods, low 1-2 tick periods, repeating; every low gap >= 16 clk.
REQ-031 1-clk act[1] pulse while channel 1 in OFF -> at OFF expiry direct OFF->ON transition; led[1] rises in same cycle IDLE would have been entered.
REQ-032 d25=1 and rst_n released -> tick=0; tick first pulses one clk after the next 0->1 transition of d25.
REQ-033 locked=1, d28 toggling -> hb equals d28 delayed 1 clk; locked driven 0 -> hb equals d25 delayed 1 clk from next cycle.
REQ-034 rst_n=0 for 1 clk while led[0]=1 and pend[0]=1 -> led[0]=0, hb=0 next clk; led[0] stays 0 with act idle afterwards.
